// File: rtl/lab1_pkg.sv
// rtl/lab1_pkg.sv - speed-level constants and step-period lookup for the address sequencer
package lab1_pkg;

  localparam int LVL_W       = 3;
  localparam int NUM_LVL     = 5;
  localparam int DEF_LVL     = 2;
  localparam int BASE_PERIOD = 4;

  // Each level below the fastest doubles the step period.
  function automatic int period_of(input int lvl, input int base, input int num_lvl);
    return base << (num_lvl - 1 - lvl);
  endfunction

endpackage

// File: rtl/addr_sequencer_if.sv
// rtl/addr_sequencer_if.sv - control inputs and address/status outputs of the sequencer
interface addr_sequencer_if #(
  parameter int ADDR_W = 8
);

  logic              pause;
  logic              speedup;
  logic              speeddown;
  logic [ADDR_W-1:0] addr;
  logic              step;
  logic [2:0]        speed_lvl;
  logic              paused;

  modport master (
    output pause, speedup, speeddown,
    input  addr, step, speed_lvl, paused
  );

  modport slave (
    input  pause, speedup, speeddown,
    output addr, step, speed_lvl, paused
  );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with a one-cycle rising-edge pulse
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/addr_sequencer.sv
// rtl/addr_sequencer.sv - steps a ROM address at a speed-level-dependent period with pause
module addr_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int ADDR_LAST   = 255,
  parameter int BASE_PERIOD = lab1_pkg::BASE_PERIOD,
  parameter int NUM_LVL     = lab1_pkg::NUM_LVL,
  parameter int DEF_LVL     = lab1_pkg::DEF_LVL
) (
  input  logic             clk,
  input  logic             rst_n,
  addr_sequencer_if.slave  bus
);

  import lab1_pkg::*;

  localparam int CNT_W = $clog2(BASE_PERIOD << (NUM_LVL - 1));

  logic             pause_s;
  logic             up_e;
  logic             dn_e;
  logic             unused_up_lvl;
  logic             unused_dn_lvl;
  logic [LVL_W-1:0] lvl;
  logic [LVL_W-1:0] lvl_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_m1;
  logic [ADDR_W-1:0] addr;
  logic             step;
  logic             lvl_chg;

  sync_edge u_pause (.clk(clk), .rst_n(rst_n), .din(bus.pause),     .level(pause_s),       .rise());
  sync_edge u_up    (.clk(clk), .rst_n(rst_n), .din(bus.speedup),   .level(unused_up_lvl), .rise(up_e));
  sync_edge u_dn    (.clk(clk), .rst_n(rst_n), .din(bus.speeddown), .level(unused_dn_lvl), .rise(dn_e));

  // Simultaneous up/down edges cancel; the level saturates at both ends.
  always_comb begin
    lvl_nxt = lvl;
    if (up_e && !dn_e && (lvl < LVL_W'(NUM_LVL - 1))) begin
      lvl_nxt = lvl + 1'b1;
    end else if (dn_e && !up_e && (lvl != '0)) begin
      lvl_nxt = lvl - 1'b1;
    end
  end

  assign lvl_chg   = (lvl_nxt != lvl);
  assign period_m1 = CNT_W'(period_of(int'(lvl), BASE_PERIOD, NUM_LVL) - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= LVL_W'(DEF_LVL);
    end else begin
      lvl <= lvl_nxt;
    end
  end

  // A terminal count wins over a level change so no step is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      addr <= '0;
      step <= 1'b0;
    end else if (pause_s) begin
      step <= 1'b0;
    end else if (cnt == period_m1) begin
      cnt  <= '0;
      addr <= (addr == ADDR_W'(ADDR_LAST)) ? '0 : addr + 1'b1;
      step <= 1'b1;
    end else if (lvl_chg) begin
      cnt  <= '0;
      step <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      step <= 1'b0;
    end
  end

  assign bus.addr      = addr;
  assign bus.step      = step;
  assign bus.speed_lvl = lvl;
  assign bus.paused    = pause_s;

endmodule

// File: tb/tb_addr_sequencer.sv
// tb/tb_addr_sequencer.sv - directed self-checking bench for addr_sequencer
module tb_addr_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  addr_sequencer_if #(.ADDR_W(8)) bus ();

  addr_sequencer #(
    .ADDR_W(8), .ADDR_LAST(255), .BASE_PERIOD(4), .NUM_LVL(5), .DEF_LVL(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Cycles until the next step pulse; -1 when none arrives within the bound.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.step !== 1'b1 && n < 200);
    if (bus.step !== 1'b1) n = -1;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.pause     = 1'b0;
    bus.speedup   = 1'b0;
    bus.speeddown = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.pause = 1'b0; bus.speedup = 1'b0; bus.speeddown = 1'b0;
    ticks(2);
    vectors++;
    if (bus.addr !== 8'd0) begin miscompares++; $display("FAIL reset_addr got=%0d exp=0", bus.addr); end
    vectors++;
    if (bus.step !== 1'b0) begin miscompares++; $display("FAIL reset_step got=%b exp=0", bus.step); end
    vectors++;
    if (bus.speed_lvl !== 3'd2) begin miscompares++; $display("FAIL reset_lvl got=%0d exp=2", bus.speed_lvl); end
    vectors++;
    if (bus.paused !== 1'b0) begin miscompares++; $display("FAIL reset_paused got=%b exp=0", bus.paused); end
  endtask

  task automatic test_stepping();
    int n;
    bit ok;
    rst_n = 1'b1;
    wait_step(n);
    vectors++;
    if (n !== 16 || bus.addr !== 8'd1) begin
      miscompares++; $display("FAIL first_step gap=%0d addr=%0d exp gap=16 addr=1", n, bus.addr);
    end
    wait_step(n);
    vectors++;
    if (n !== 16 || bus.addr !== 8'd2) begin
      miscompares++; $display("FAIL second_step gap=%0d addr=%0d exp gap=16 addr=2", n, bus.addr);
    end
    ok = 1'b1;
    for (int i = 0; i < 253; i++) begin
      wait_step(n);
      if (n !== 16) ok = 1'b0;
    end
    vectors++;
    if (!ok || bus.addr !== 8'd255) begin
      miscompares++; $display("FAIL run_to_last spacing_ok=%b addr=%0d exp addr=255", ok, bus.addr);
    end
    wait_step(n);
    vectors++;
    if (n !== 16 || bus.addr !== 8'd0 || bus.step !== 1'b1) begin
      miscompares++; $display("FAIL wrap gap=%0d addr=%0d step=%b exp gap=16 addr=0 step=1", n, bus.addr, bus.step);
    end
  endtask

  task automatic test_pause();
    int n;
    bit held;
    ticks(3);
    bus.pause = 1'b1;
    tick();
    vectors++;
    if (bus.paused !== 1'b0) begin miscompares++; $display("FAIL paused_early got=%b exp=0", bus.paused); end
    tick();
    vectors++;
    if (bus.paused !== 1'b1) begin miscompares++; $display("FAIL paused_latency got=%b exp=1", bus.paused); end
    held = 1'b1;
    for (int i = 0; i < 38; i++) begin
      tick();
      if (bus.step !== 1'b0 || bus.addr !== 8'd0) held = 1'b0;
    end
    vectors++;
    if (!held) begin miscompares++; $display("FAIL pause_hold step=%b addr=%0d exp step=0 addr=0", bus.step, bus.addr); end
    bus.pause = 1'b0;
    ticks(2);
    vectors++;
    if (bus.paused !== 1'b0) begin miscompares++; $display("FAIL unpause got=%b exp=0", bus.paused); end
    wait_step(n);
    vectors++;
    if (n !== 11 || bus.addr !== 8'd1) begin
      miscompares++; $display("FAIL resume gap=%0d addr=%0d exp gap=11 addr=1", n, bus.addr);
    end
  endtask

  task automatic test_speedup_hold();
    int n;
    ticks(3);
    bus.speedup = 1'b1;
    ticks(2);
    vectors++;
    if (bus.speed_lvl !== 3'd2) begin miscompares++; $display("FAIL up_early got=%0d exp=2", bus.speed_lvl); end
    tick();
    vectors++;
    if (bus.speed_lvl !== 3'd3) begin miscompares++; $display("FAIL up_edge got=%0d exp=3", bus.speed_lvl); end
    wait_step(n);
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL up_cnt_clear gap=%0d exp=8", n); end
    wait_step(n);
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL lvl3_spacing gap=%0d exp=8", n); end
    ticks(81);
    vectors++;
    if (bus.speed_lvl !== 3'd3) begin miscompares++; $display("FAIL up_held got=%0d exp=3", bus.speed_lvl); end
    bus.speedup = 1'b0;
    ticks(3);
  endtask

  task automatic test_levels();
    int n;
    logic [2:0] exp_up [4] = '{3'd3, 3'd4, 3'd4, 3'd4};
    logic [2:0] exp_dn [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.speedup = 1'b1;
      ticks(3);
      vectors++;
      if (bus.speed_lvl !== exp_up[i]) begin
        miscompares++; $display("FAIL up_pulse_%0d got=%0d exp=%0d", i, bus.speed_lvl, exp_up[i]);
      end
      bus.speedup = 1'b0;
      ticks(3);
    end
    wait_step(n);
    wait_step(n);
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL lvl4_spacing gap=%0d exp=4", n); end
    for (int i = 0; i < 5; i++) begin
      bus.speeddown = 1'b1;
      ticks(3);
      vectors++;
      if (bus.speed_lvl !== exp_dn[i]) begin
        miscompares++; $display("FAIL dn_pulse_%0d got=%0d exp=%0d", i, bus.speed_lvl, exp_dn[i]);
      end
      bus.speeddown = 1'b0;
      ticks(3);
    end
    wait_step(n);
    wait_step(n);
    vectors++;
    if (n !== 64) begin miscompares++; $display("FAIL lvl0_spacing gap=%0d exp=64", n); end
  endtask

  task automatic test_both_edges();
    int n;
    bit quiet;
    apply_reset();
    ticks(2);
    bus.speedup   = 1'b1;
    bus.speeddown = 1'b1;
    ticks(3);
    vectors++;
    if (bus.speed_lvl !== 3'd2) begin miscompares++; $display("FAIL both_edges got=%0d exp=2", bus.speed_lvl); end
    bus.speedup   = 1'b0;
    bus.speeddown = 1'b0;
    wait_step(n);
    wait_step(n);
    vectors++;
    if (n !== 16) begin miscompares++; $display("FAIL both_spacing gap=%0d exp=16", n); end
    bus.pause = 1'b1;
    ticks(2);
    vectors++;
    if (bus.paused !== 1'b1) begin miscompares++; $display("FAIL pause_for_lvl got=%b exp=1", bus.paused); end
    bus.speedup = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.step !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (bus.speed_lvl !== 3'd3 || !quiet) begin
      miscompares++; $display("FAIL lvl_while_paused lvl=%0d quiet=%b exp lvl=3 quiet=1", bus.speed_lvl, quiet);
    end
    bus.speedup = 1'b0;
    ticks(3);
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      bus.speedup = 1'b1;
      ticks(3);
      bus.speedup = 1'b0;
      ticks(3);
    end
    for (int i = 0; i < 20 && bus.addr !== 8'd7; i++) wait_step(n);
    bus.pause = 1'b1;
    ticks(2);
    vectors++;
    if (bus.addr !== 8'd7 || bus.speed_lvl !== 3'd4 || bus.paused !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset addr=%0d lvl=%0d paused=%b exp addr=7 lvl=4 paused=1",
                              bus.addr, bus.speed_lvl, bus.paused);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.addr !== 8'd0 || bus.step !== 1'b0 || bus.speed_lvl !== 3'd2 || bus.paused !== 1'b0) begin
      miscompares++; $display("FAIL async_reset addr=%0d step=%b lvl=%0d paused=%b exp 0/0/2/0",
                              bus.addr, bus.step, bus.speed_lvl, bus.paused);
    end
    bus.pause = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_step(n);
    vectors++;
    if (n !== 16 || bus.addr !== 8'd1) begin
      miscompares++; $display("FAIL restart gap=%0d addr=%0d exp gap=16 addr=1", n, bus.addr);
    end
  endtask

  initial begin
    bus.pause     = 1'b0;
    bus.speedup   = 1'b0;
    bus.speeddown = 1'b0;
    test_reset();
    test_stepping();
    test_pause();
    test_speedup_hold();
    test_levels();
    test_both_edges();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
